part_mux_sel_reg: RTL
=====================

# part_mux_sel_reg

Parametrised, registered multi-group data selector: the next-generation replacement for the dual 4-line-to-1-line selector parts. It provides GROUPS independent groups, each selecting one of INPUTS words of WIDTH bits. All groups share one select register, which is either loaded directly or stepped by an internal scan counter. Group outputs are registered, so the block drops into clocked datapaths such as bus sequencers and time-multiplexed readout without external latches.

## Interface
- WIDTH, 1: bits per data word.
- INPUTS, 4: data inputs per group; power of two, ≥2. SELW = log2(INPUTS), derived localparam.
- GROUPS, 2: number of independent groups, ≥1.

- CLK  input  1  clock; all state changes on rising edge.
- RESET_N  input  1  reset, synchronous, active-low.
- D  input  GROUPS*INPUTS*WIDTH  data; group g, input i at D[(g*INPUTS+i)*WIDTH +: WIDTH].
- SEL  input  SELW  select value for LOAD_SEL.
- LOAD_SEL  input  1  load SEL into select register.
- SCAN  input  1  advance select register by 1 (mod INPUTS).
- ENB_N  input  GROUPS  per-group enable, active-low.
- Q  output  GROUPS*WIDTH  registered group outputs; group g at Q[g*WIDTH +: WIDTH].
- QVALID  output  GROUPS  registered copy of ~ENB_N.
- SEL_Q  output  SELW  current select register value.
- WRAP  output  1  one-cycle pulse: scan stepped INPUTS-1 -> 0.

## Operation
- Select register S (SELW bits), visible on SEL_Q.
- Per rising CLK, RESET_N=1, S update priority:
  - LOAD_SEL=1: S <= SEL (SCAN ignored).
  - else SCAN=1: S <= (S+1) mod INPUTS.
  - else S holds.
- WRAP <= 1 only when SCAN=1, LOAD_SEL=0, S==INPUTS-1; otherwise WRAP <= 0. LOAD_SEL of 0 never asserts WRAP.
- Group g, every edge:
  - ENB_N[g]=0: Q_g <= D word (g, S), using S before this edge's update.
  - ENB_N[g]=1: Q_g <= 0 (default build; see Configuration).
  - QVALID[g] <= ~ENB_N[g].
- Groups are independent; a disabled group does not affect S or other groups.
- Select arithmetic is unsigned SELW-bit, wrapping naturally; there are no out-of-range values.

## Timing
- Reset: RESET_N=0 at an edge → S=0, SEL_Q=0, Q=0, QVALID=0, WRAP=0. This overrides LOAD_SEL, SCAN, and ENB_N. Reset mid-scan returns S to 0 with no WRAP.
- Latency D/ENB_N → Q/QVALID: 1 cycle.
- Latency SEL+LOAD_SEL → SEL_Q: 1 cycle. Q reflects the new select at the edge after that, 2 cycles from LOAD_SEL.
- Scan: with SCAN held, SEL_Q steps once per cycle. Q lags SEL_Q by 1 cycle.
- WRAP is coincident with SEL_Q becoming 0 by scan.
- First cycle after reset release: Q samples word 0 of each enabled group.
- No combinational path from inputs to outputs.

## Configuration
- Macro MUX153_HOLD_EN.
- Undefined: a disabled group's Q_g clears to 0 at each edge, matching the legacy parts' low-when-disabled behaviour.
- Defined: a disabled group's Q_g holds its previous value. QVALID still follows ~ENB_N. Reset still clears Q to 0.

## Test plan
- Reset: drive D all-ones, ENB_N=0, SCAN=1, RESET_N=0 for 2 edges → Q=0, SEL_Q=0, QVALID=0, WRAP=0.
- Direct select (defaults): group0 inputs 0..3 = 1,0,1,0 and group1 = 0,1,1,0. LOAD_SEL with SEL=2 → SEL_Q=2 next cycle, then Q={g1=1,g0=1}. Then SEL=1 → Q={1,0}.
- Scan wrap (WIDTH=8, INPUTS=4, GROUPS=1): D words 0x11,0x22,0x33,0x44, SCAN held → SEL_Q 0,1,2,3,0; Q lags one cycle: 0x11,0x22,0x33,0x44,0x11. WRAP=1 exactly in the cycle SEL_Q returns to 0.
- Priority: S=3, LOAD_SEL=1, SEL=1, SCAN=1 in the same cycle → SEL_Q=1, WRAP=0.
- Enable: ENB_N=2'b10 with group1 input high → Q_g1=0, QVALID=2'b01. With MUX153_HOLD_EN defined, Q_g1 keeps its prior value of 1.
- Reset mid-scan at SEL_Q=2 → SEL_Q=0, no WRAP pulse. After release, scanning resumes from 0 → 1.

Source files
------------

// File: rtl/part_mux_sel_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : part_mux_sel_reg_if
// Description : Bundle of data, control and result signals for the
//               registered multi-group selector part_mux_sel_reg.
//               master : drives d, sel, load_sel, scan, enb_n;
//                        observes q, qvalid, sel_q, wrap.
//               slave  : the selector itself (opposite directions).
//               d      : GROUPS*INPUTS*WIDTH, group g input i at
//                        d[(g*INPUTS+i)*WIDTH +: WIDTH]
//               q      : GROUPS*WIDTH, group g at q[g*WIDTH +: WIDTH]
// Revision    : 1.0  initial release
// ============================================================================
interface part_mux_sel_reg_if #(
  parameter int WIDTH  = 1,
  parameter int INPUTS = 4,
  parameter int GROUPS = 2
);
  localparam int SELW = $clog2(INPUTS);

  logic [GROUPS*INPUTS*WIDTH-1:0] d;
  logic [SELW-1:0]                sel;
  logic                           load_sel;
  logic                           scan;
  logic [GROUPS-1:0]              enb_n;
  logic [GROUPS*WIDTH-1:0]        q;
  logic [GROUPS-1:0]              qvalid;
  logic [SELW-1:0]                sel_q;
  logic                           wrap;

  modport master (
    output d, sel, load_sel, scan, enb_n,
    input  q, qvalid, sel_q, wrap
  );

  modport slave (
    input  d, sel, load_sel, scan, enb_n,
    output q, qvalid, sel_q, wrap
  );
endinterface
`default_nettype wire

// File: rtl/part_mux_sel_reg.sv
`default_nettype none
// ============================================================================
// Module      : part_mux_sel_reg
// Description : Registered multi-group data selector. GROUPS independent
//               groups each pick one of INPUTS words of WIDTH bits, all
//               steered by one shared select register that is either loaded
//               from sel or stepped by scan. All outputs are registered.
//
//               clk      : clock, rising edge active
//               reset_n  : synchronous, active-low reset
//               bus      : part_mux_sel_reg_if.slave
//                 d/sel/load_sel/scan/enb_n in, q/qvalid/sel_q/wrap out
//
//               Build option MUX153_HOLD_EN:
//                 undefined -> a disabled group's q clears to 0 each edge
//                 defined   -> a disabled group's q holds its last value
// Revision    : 1.0  initial release
// ============================================================================
module part_mux_sel_reg #(
  parameter int WIDTH  = 1,
  parameter int INPUTS = 4,
  parameter int GROUPS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  part_mux_sel_reg_if.slave bus
);
  localparam int SELW = $clog2(INPUTS);
  localparam logic [SELW-1:0] C_SEL_ONE = SELW'(1);

  logic [SELW-1:0] r_sel;
  logic            r_wrap;

  // Select register: load has priority over scan. INPUTS is a power of
  // two, so the SELW-bit increment wraps to 0 on its own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sel  <= '0;
      r_wrap <= 1'b0;
    end else begin
      // All-ones select is the last input; a plain scan from there wraps.
      r_wrap <= bus.scan && !bus.load_sel && (&r_sel);
      if (bus.load_sel) begin
        r_sel <= bus.sel;
      end else if (bus.scan) begin
        r_sel <= r_sel + C_SEL_ONE;
      end
    end
  end

  assign bus.sel_q = r_sel;
  assign bus.wrap  = r_wrap;

  for (genvar g = 0; g < GROUPS; g++) begin : g_group
    logic [WIDTH-1:0] w_words [INPUTS];
    logic [WIDTH-1:0] r_q;
    logic             r_qvalid;

    for (genvar i = 0; i < INPUTS; i++) begin : g_word
      assign w_words[i] = bus.d[(g*INPUTS+i)*WIDTH +: WIDTH];
    end

    // The word is picked with the select value held before this edge,
    // which is why q trails sel_q by one cycle.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_q      <= '0;
        r_qvalid <= 1'b0;
      end else begin
        r_qvalid <= ~bus.enb_n[g];
        if (!bus.enb_n[g]) begin
          r_q <= w_words[r_sel];
        end else begin
`ifdef MUX153_HOLD_EN
          r_q <= r_q;
`else
          r_q <= '0;
`endif
        end
      end
    end

    assign bus.q[g*WIDTH +: WIDTH] = r_q;
    assign bus.qvalid[g]           = r_qvalid;
  end

endmodule
`default_nettype wire
